// File: rtl/rgmii_pkg.sv
// Shared definitions for the RGMII receive front end.
//   DELAY_STEP_MAX : largest delay-line step the receive clock delay accepts
//   bin2gray       : binary to reflected gray code, 8 bits
//   clamp_step     : clamps a signed step request into 0..DELAY_STEP_MAX
package rgmii_pkg;

  localparam int DELAY_STEP_MAX = 247;

  // Gray coding keeps the delay-line control word single-bit-changing
  // between neighbouring steps.
  function automatic logic [7:0] bin2gray(input logic [7:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // The binary request plus a signed trim can leave the legal range in
  // either direction, so it is pinned to the nearest valid step.
  function automatic logic [7:0] clamp_step(input int step);
    logic [7:0] result;
    if (step < 0)
      result = 8'd0;
    else if (step > DELAY_STEP_MAX)
      result = 8'(DELAY_STEP_MAX);
    else
      result = step[7:0];
    return result;
  endfunction

endpackage

// File: rtl/rgmii_rx_capture_ddr_in_cell.sv
// One-bit dual-edge input capture for RGMII receive.
//   i_clk   : buffered RGMII receive clock, both edges used
//   i_rst_n : asynchronous active-low reset
//   i_d     : pad bit after input buffer
//   o_rise  : bit sampled on the rising edge, re-timed to the next rising edge
//   o_fall  : bit sampled on the following falling edge, re-timed to the same
//             rising edge so the two halves leave the cell as one pair
module ddr_in_cell
  import rgmii_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_rise,
  output logic o_fall
);

  logic r_rise;
  logic r_fall;
  logic r_pairRise;
  logic r_pairFall;

  // Rising-edge capture of the first half of the DDR bit.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      r_rise <= 1'b0;
    else
      r_rise <= i_d;
  end

  // Falling-edge capture of the second half; cleared by reset like every
  // other stage so no stale half-nibble survives a reset.
  always_ff @(negedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      r_fall <= 1'b0;
    else
      r_fall <= i_d;
  end

  // Pair stage: both halves move into the rising-edge domain together.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pairRise <= 1'b0;
      r_pairFall <= 1'b0;
    end else begin
      r_pairRise <= r_rise;
      r_pairFall <= r_fall;
    end
  end

  assign o_rise = r_pairRise;
  assign o_fall = r_pairFall;

endmodule

// File: rtl/rgmii_rx_capture.sv
// RGMII receive capture: rebuilds GMII byte/valid/error from DDR pads and
// provides a lock flag and gray-coded delay word for the RX clock delay line.
//   rgmii_clk         : buffered RGMII receive clock (both edges used)
//   rst_n             : asynchronous active-low reset
//   rgmii_rx_ctl      : RX_CTL pad
//   rgmii_rxd[3:0]    : RXD pads
//   mac_rx_data[7:0]  : GMII receive byte (low nibble = rising-edge nibble)
//   mac_rx_data_valid : GMII RX_DV
//   mac_rx_error      : GMII RX_ER
//   dll_lock          : high once LOCK_CYCLES rising edges have passed
//   delay_step_gray   : gray-coded delay step, 0 until locked
module rgmii_rx_capture
  import rgmii_pkg::*;
#(
  parameter logic [7:0] DELAY_STEP_BIN    = 8'hA0,
  parameter int         DELAY_STEP_OFFSET = 0,
  parameter int         LOCK_CYCLES       = 16
) (
  input  logic       rgmii_clk,
  input  logic       rst_n,
  input  logic       rgmii_rx_ctl,
  input  logic [3:0] rgmii_rxd,
  output logic [7:0] mac_rx_data,
  output logic       mac_rx_data_valid,
  output logic       mac_rx_error,
  output logic       dll_lock,
  output logic [7:0] delay_step_gray
);

  localparam logic [7:0] STEP_GRAY  =
    bin2gray(clamp_step(int'(DELAY_STEP_BIN) + DELAY_STEP_OFFSET));
  localparam logic [7:0] LOCK_COUNT = 8'(LOCK_CYCLES);

  logic [3:0] w_riseD;
  logic [3:0] w_fallD;
  logic       w_ctlRise;
  logic       w_ctlFall;
  logic [7:0] w_pairData;
  logic       w_pairDv;
  logic       w_pairEr;
  logic [7:0] w_cntNext;
  logic       w_lockNext;

  logic [7:0] r_cnt;
  logic       r_lock;
  logic [7:0] r_gray;
  logic [7:0] r_data;
  logic       r_dv;
  logic       r_er;

  // One DDR cell per data pad; together they deliver a nibble pair per cycle.
  for (genvar g = 0; g < 4; g++) begin : gen_rxd
    ddr_in_cell u_cell (
      .i_clk   (rgmii_clk),
      .i_rst_n (rst_n),
      .i_d     (rgmii_rxd[g]),
      .o_rise  (w_riseD[g]),
      .o_fall  (w_fallD[g])
    );
  end

  ddr_in_cell u_ctlCell (
    .i_clk   (rgmii_clk),
    .i_rst_n (rst_n),
    .i_d     (rgmii_rx_ctl),
    .o_rise  (w_ctlRise),
    .o_fall  (w_ctlFall)
  );

  // RGMII carries DV on the rising edge and DV XOR ER on the falling edge.
  assign w_pairData = {w_fallD, w_riseD};
  assign w_pairDv   = w_ctlRise;
  assign w_pairEr   = w_ctlRise ^ w_ctlFall;

  // Lock asserts on the edge where the saturating count reaches LOCK_COUNT
  // and is then held until reset.
  assign w_cntNext  = (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;
  assign w_lockNext = r_lock | (w_cntNext >= LOCK_COUNT);

  // Lock counter, lock flag and delay word; the delay word switches on the
  // same edge as the lock flag so the delay line sees both together.
  always_ff @(posedge rgmii_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= 8'd0;
      r_lock <= 1'b0;
      r_gray <= 8'd0;
    end else begin
      r_cnt  <= w_cntNext;
      r_lock <= w_lockNext;
      r_gray <= w_lockNext ? STEP_GRAY : 8'd0;
    end
  end

  // Output register; loads are forced to zero until the lock flag is
  // already high, so pairs captured during lock-up never reach the MAC.
  always_ff @(posedge rgmii_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= 8'd0;
      r_dv   <= 1'b0;
      r_er   <= 1'b0;
    end else if (r_lock) begin
      r_data <= w_pairData;
      r_dv   <= w_pairDv;
      r_er   <= w_pairEr;
    end else begin
      r_data <= 8'd0;
      r_dv   <= 1'b0;
      r_er   <= 1'b0;
    end
  end

  assign mac_rx_data       = r_data;
  assign mac_rx_data_valid = r_dv;
  assign mac_rx_error      = r_er;
  assign dll_lock          = r_lock;
  assign delay_step_gray   = r_gray;

endmodule

// File: tb/tb_rgmii_rx_capture.sv
// Directed self-checking bench for rgmii_rx_capture: reset state, lock-up
// timing, pre-lock suppression, byte rebuild and control decode, streaming,
// mid-frame reset, and delay-word clamping on two extra instances.
module tb_rgmii_rx_capture;

  logic       clk;
  logic       rstN;
  logic       rxCtl;
  logic [3:0] rxd;

  logic [7:0] macData;
  logic       macDv;
  logic       macEr;
  logic       lock;
  logic [7:0] gray;

  logic [7:0] hiData;
  logic       hiDv;
  logic       hiEr;
  logic       hiLock;
  logic [7:0] hiGray;

  logic [7:0] loData;
  logic       loDv;
  logic       loEr;
  logic       loLock;
  logic [7:0] loGray;

  int checks = 0;
  int errors = 0;

  rgmii_rx_capture dut (
    .rgmii_clk         (clk),
    .rst_n             (rstN),
    .rgmii_rx_ctl      (rxCtl),
    .rgmii_rxd         (rxd),
    .mac_rx_data       (macData),
    .mac_rx_data_valid (macDv),
    .mac_rx_error      (macEr),
    .dll_lock          (lock),
    .delay_step_gray   (gray)
  );

  rgmii_rx_capture #(.DELAY_STEP_BIN(8'd250), .DELAY_STEP_OFFSET(0)) dutClampHi (
    .rgmii_clk         (clk),
    .rst_n             (rstN),
    .rgmii_rx_ctl      (rxCtl),
    .rgmii_rxd         (rxd),
    .mac_rx_data       (hiData),
    .mac_rx_data_valid (hiDv),
    .mac_rx_error      (hiEr),
    .dll_lock          (hiLock),
    .delay_step_gray   (hiGray)
  );

  rgmii_rx_capture #(.DELAY_STEP_BIN(8'h10), .DELAY_STEP_OFFSET(-32)) dutClampLo (
    .rgmii_clk         (clk),
    .rst_n             (rstN),
    .rgmii_rx_ctl      (rxCtl),
    .rgmii_rxd         (rxd),
    .mac_rx_data       (loData),
    .mac_rx_data_valid (loDv),
    .mac_rx_error      (loEr),
    .dll_lock          (loLock),
    .delay_step_gray   (loGray)
  );

  // 10 ns receive clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: counts it, and on mismatch counts and reports it.
  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Checks the three MAC outputs together.
  task automatic checkMac(input string tag, input logic [7:0] d, input logic dv, input logic er);
    checkOutput({tag, " data"}, macData, d);
    checkOutput({tag, " dv"}, {7'd0, macDv}, {7'd0, dv});
    checkOutput({tag, " er"}, {7'd0, macEr}, {7'd0, er});
  endtask

  // Drives one DDR byte around exactly one rising edge. Entered just after a
  // rising edge; returns 1 ns after the rising edge that samples the low
  // nibble, leaving the high nibble on the pads for the next falling edge.
  task automatic applyStimulus(input logic [7:0] b, input logic ctlRise, input logic ctlFall);
    @(negedge clk);
    #1;
    rxd   = b[3:0];
    rxCtl = ctlRise;
    @(posedge clk);
    #1;
    rxd   = b[7:4];
    rxCtl = ctlFall;
  endtask

  initial begin
    rstN  = 1'b0;
    rxCtl = 1'b0;
    rxd   = 4'h0;

    #1;
    checkMac("reset", 8'h00, 1'b0, 1'b0);
    checkOutput("reset lock", {7'd0, lock}, 8'h00);
    checkOutput("reset gray", gray, 8'h00);

    @(posedge clk);
    @(posedge clk);
    #1 rstN = 1'b1;

    // Lock-up with a valid 0xFF frame on the pads: MAC outputs stay quiet.
    for (int i = 1; i <= 16; i++) begin
      applyStimulus(8'hFF, 1'b1, 1'b1);
      checkMac($sformatf("prelock edge%0d", i), 8'h00, 1'b0, 1'b0);
      if (i == 15) begin
        checkOutput("lock edge15", {7'd0, lock}, 8'h00);
        checkOutput("gray edge15", gray, 8'h00);
      end
      if (i == 16) begin
        checkOutput("lock edge16", {7'd0, lock}, 8'h01);
        checkOutput("gray edge16", gray, 8'hF0);
        checkOutput("clampHi gray", hiGray, 8'h8C);
        checkOutput("clampLo gray", loGray, 8'h00);
        checkOutput("clampLo lock", {7'd0, loLock}, 8'h01);
      end
    end

    // Pairs from edges 15/16 load after lock and are delivered.
    applyStimulus(8'h00, 1'b0, 1'b0);
    checkMac("postlock edge17", 8'hFF, 1'b1, 1'b0);
    applyStimulus(8'h00, 1'b0, 1'b0);
    checkMac("postlock edge18", 8'hFF, 1'b1, 1'b0);

    // Stream: each output reflects the byte driven two edges earlier.
    applyStimulus(8'h5A, 1'b1, 1'b1);
    checkMac("idle edge19", 8'h00, 1'b0, 1'b0);
    applyStimulus(8'h55, 1'b1, 1'b1);
    checkMac("idle edge20", 8'h00, 1'b0, 1'b0);
    applyStimulus(8'hD5, 1'b1, 1'b1);
    checkMac("byte 5A", 8'h5A, 1'b1, 1'b0);
    applyStimulus(8'h01, 1'b1, 1'b1);
    checkMac("stream 55", 8'h55, 1'b1, 1'b0);
    applyStimulus(8'h3C, 1'b1, 1'b0);
    checkMac("stream D5", 8'hD5, 1'b1, 1'b0);
    applyStimulus(8'hAA, 1'b0, 1'b1);
    checkMac("stream 01", 8'h01, 1'b1, 1'b0);
    applyStimulus(8'h77, 1'b0, 1'b0);
    checkMac("ctl 10 err", 8'h3C, 1'b1, 1'b1);
    applyStimulus(8'h00, 1'b0, 1'b0);
    checkOutput("ctl 01 dv", {7'd0, macDv}, 8'h00);
    checkOutput("ctl 01 er", {7'd0, macEr}, 8'h01);
    applyStimulus(8'h00, 1'b0, 1'b0);
    checkOutput("ctl 00 dv", {7'd0, macDv}, 8'h00);
    checkOutput("ctl 00 er", {7'd0, macEr}, 8'h00);

    // Mid-frame reset: outputs clear without waiting for a clock edge.
    applyStimulus(8'hE7, 1'b1, 1'b1);
    applyStimulus(8'hE7, 1'b1, 1'b1);
    applyStimulus(8'hE7, 1'b1, 1'b1);
    checkMac("midframe", 8'hE7, 1'b1, 1'b0);
    #2 rstN = 1'b0;
    #1;
    checkMac("async reset", 8'h00, 1'b0, 1'b0);
    checkOutput("async reset lock", {7'd0, lock}, 8'h00);
    checkOutput("async reset gray", gray, 8'h00);

    @(posedge clk);
    #1 rstN = 1'b1;

    // Relock: another 16 edges, data during relock discarded.
    for (int i = 1; i <= 16; i++) begin
      applyStimulus(8'hC3, 1'b1, 1'b1);
      checkMac($sformatf("relock edge%0d", i), 8'h00, 1'b0, 1'b0);
      if (i == 15)
        checkOutput("relock lock edge15", {7'd0, lock}, 8'h00);
      if (i == 16) begin
        checkOutput("relock lock edge16", {7'd0, lock}, 8'h01);
        checkOutput("relock gray edge16", gray, 8'hF0);
      end
    end
    applyStimulus(8'h00, 1'b0, 1'b0);
    checkMac("relock delivered", 8'hC3, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
